// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer
// Packs a byte stream into 32-bit words for the keccak core and generates the
// core's end-of-message framing (including the empty final word when the
// message length is a multiple of 4). One message per reset.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   byte input stream
//   in/in_ready/is_last/byte_num    word output to the core
//   buffer_full      core backpressure
//   msg_len          bytes accepted since reset (wraps)
//   done             final word transferred (sticky until reset)
//   state_o          current FSM state (debug observation)
//
// Handshakes: a byte transfers on a rising edge where s_valid && s_ready; a
// word transfers on a rising edge where in_ready && !buffer_full (w_fire).
// While in_ready && buffer_full the presented word and its framing are held
// stable. s_ready depends on buffer_full but never on s_data or s_last.
module keccak_byte_packer #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      in,
    output logic             in_ready,
    output logic             is_last,
    output logic [1:0]       byte_num,
    input  logic             buffer_full,
    output logic [LEN_W-1:0] msg_len,
    output logic             done,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       acc_q, acc_d;
    logic [31:0]       word_q, word_d;
    logic              out_valid_q, out_valid_d;
    logic              last_q, last_d;
    logic [1:0]        bn_q, bn_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              done_q, done_d;

    logic              w_fire;
    logic              out_free;
    logic              accept;
    logic [31:0]       merged;

    assign w_fire   = out_valid_q && !buffer_full;
    // Output register can take a new word if empty or emptying this cycle.
    assign out_free = !out_valid_q || w_fire;
    // Gated by reset so s_ready reads 0 while reset is held.
    assign s_ready  = !reset && (state_q == ST_RUN) && out_free;
    assign accept   = s_valid && s_ready;

    // Accumulated bytes with the incoming byte dropped into lane cnt.
    // Lanes above cnt are zero because acc is cleared whenever a word is built.
    always_comb begin
        merged = {acc_q, 8'h00};
        case (cnt_q)
            2'd0:    merged[31:24] = s_data;
            2'd1:    merged[23:16] = s_data;
            2'd2:    merged[15:8]  = s_data;
            default: merged[7:0]   = s_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        bn_d        = bn_q;
        len_d       = len_q;
        done_d      = done_q;

        if (w_fire) begin
            out_valid_d = 1'b0;
            if (last_q) done_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    len_d = len_q + LEN_W'(1);
                    if (cnt_q == 2'd3) begin
                        word_d      = {acc_q, s_data};
                        out_valid_d = 1'b1;
                        last_d      = 1'b0;
                        bn_d        = 2'd0;
                        cnt_d       = 2'd0;
                        acc_d       = 24'h0;
                        // Full final word: the core still needs an empty last word.
                        if (s_last) state_d = ST_FLUSH;
                    end else if (s_last) begin
                        word_d      = merged;
                        out_valid_d = 1'b1;
                        last_d      = 1'b1;
                        bn_d        = cnt_q + 2'd1;
                        cnt_d       = 2'd0;
                        acc_d       = 24'h0;
                        state_d     = ST_DONE;
                    end else begin
                        acc_d = merged[31:8];
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    word_d      = 32'h0;
                    last_d      = 1'b1;
                    bn_d        = 2'd0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // Idle until reset; the core needs a reset between messages.
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            acc_q       <= 24'h0;
            word_q      <= 32'h0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            bn_q        <= 2'd0;
            len_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            bn_q        <= bn_d;
            len_q       <= len_d;
            done_q      <= done_d;
        end
    end

    assign in       = word_q;
    assign in_ready = out_valid_q;
    assign is_last  = out_valid_q & last_q;
    assign byte_num = is_last ? bn_q : 2'd0;
    assign msg_len  = len_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
module tb_keccak_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] in;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic [31:0] msg_len;
    logic        done;
    logic [1:0]  state_o;

    keccak_byte_packer #(.LEN_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .msg_len     (msg_len),
        .done        (done),
        .state_o     (state_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    // Expected words: {is_last, byte_num[1:0], word[31:0]}
    logic [34:0] exp_q[$];
    logic [7:0]  msg_q[$];
    bit          mon_en  = 0;
    bit          bf_rand = 0;
    bit          gaps_en = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Big-endian 4-byte chunking; a partial tail word carries its byte count,
    // an exact multiple of 4 gets an extra all-zero final word with count 0.
    task automatic model_expect();
        int n;
        int nfull;
        int rem;
        logic [31:0] w;
        n = msg_q.size();
        nfull = n / 4;
        rem = n % 4;
        for (int i = 0; i < nfull; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) w = w | (32'(msg_q[4*i+k]) << (24 - 8*k));
            exp_q.push_back({1'b0, 2'd0, w});
        end
        w = 32'h0;
        for (int k = 0; k < rem; k++) w = w | (32'(msg_q[4*nfull+k]) << (24 - 8*k));
        exp_q.push_back({1'b1, 2'(rem), w});
    endtask

    // ---------------- output monitor / scoreboard ----------------
    bit          hold_v = 0;
    logic [35:0] hold_snap;
    bit          last_fired = 0;
    logic [34:0] e;

    always @(negedge clk) begin
        if (!mon_en || reset) begin
            hold_v = 0;
            last_fired = 0;
        end else begin
            if (last_fired) check("done_after_last", 72'(done), 72'(1));
            last_fired = 0;
            if (hold_v) check("hold_stable", 72'({in_ready, is_last, byte_num, in}), 72'(hold_snap));
            hold_v = in_ready && buffer_full;
            hold_snap = {in_ready, is_last, byte_num, in};
            if (!in_ready) check("idle_framing", 72'({is_last, byte_num}), 72'(0));
            if (in_ready && !buffer_full) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", {is_last, byte_num, in});
                end else begin
                    e = exp_q.pop_front();
                    check("word", 72'({is_last, byte_num, in}), 72'(e));
                    if (is_last) begin
                        check("done_before_last", 72'(done), 72'(0));
                        last_fired = 1;
                    end
                end
            end
        end
    end

    // ---------------- random backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bf_rand) buffer_full = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        bf_rand = 0;
        mon_en = 0;
        s_valid = 0;
        s_last = 0;
        s_data = 8'h00;
        buffer_full = 0;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("reset_state", 72'({s_ready, in_ready, is_last, byte_num, done, in, msg_len}), 72'(0));
        @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int t;
        bit acc;
        s_valid = 1;
        s_data = b;
        s_last = last;
        t = 0;
        acc = 0;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=stalled required=accepted byte=%0h", b);
        end
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic send_msg();
        int gap;
        for (int i = 0; i < msg_q.size(); i++) begin
            send_byte(msg_q[i], (i == msg_q.size() - 1));
            if (gaps_en) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 72'(done), 72'(1));
        @(negedge clk);
        check("queue_drained", 72'(exp_q.size()), 72'(0));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          n;
        logic [7:0]  b[8];
        int          nw;
        logic [34:0] w[3];
        logic [31:0] len;
    } vec_t;

    vec_t vecs[4];

    initial begin
        s_valid = 0;
        s_last = 0;
        s_data = 0;
        buffer_full = 0;
        reset = 1;

        vecs[0].n = 5;
        vecs[0].b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h00, 8'h00, 8'h00};
        vecs[0].nw = 2;
        vecs[0].w = '{{1'b0, 2'd0, 32'h61626364}, {1'b1, 2'd1, 32'h65000000}, 35'h0};
        vecs[0].len = 32'd5;

        vecs[1].n = 4;
        vecs[1].b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nw = 2;
        vecs[1].w = '{{1'b0, 2'd0, 32'h61626364}, {1'b1, 2'd0, 32'h00000000}, 35'h0};
        vecs[1].len = 32'd4;

        vecs[2].n = 3;
        vecs[2].b = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].nw = 1;
        vecs[2].w = '{{1'b1, 2'd3, 32'hAABBCC00}, 35'h0, 35'h0};
        vecs[2].len = 32'd3;

        vecs[3].n = 7;
        vecs[3].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
        vecs[3].nw = 2;
        vecs[3].w = '{{1'b0, 2'd0, 32'h01020304}, {1'b1, 2'd3, 32'h05060700}, 35'h0};
        vecs[3].len = 32'd7;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            msg_q.delete();
            for (int k = 0; k < vecs[i].n; k++) msg_q.push_back(vecs[i].b[k]);
            for (int k = 0; k < vecs[i].nw; k++) exp_q.push_back(vecs[i].w[k]);
            mon_en = 1;
            send_msg();
            wait_done();
            check("table_msg_len", 72'(msg_len), 72'(vecs[i].len));
        end

        // 8-byte stream with the first word stalled for 10 cycles.
        do_reset();
        buffer_full = 1;
        msg_q.delete();
        for (int k = 1; k <= 8; k++) msg_q.push_back(8'(k));
        model_expect();
        mon_en = 1;
        fork
            send_msg();
            begin
                int t;
                t = 0;
                while (!in_ready && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_word_seen", 72'(in_ready), 72'(1));
                repeat (10) begin
                    @(negedge clk);
                    check("stall_s_ready", 72'(s_ready), 72'(0));
                    check("stall_in", 72'({in_ready, in}), 72'({1'b1, 32'h01020304}));
                end
                @(posedge clk);
                #1;
                buffer_full = 0;
            end
        join
        wait_done();
        check("stall_msg_len", 72'(msg_len), 72'(8));

        // After done, further bytes are ignored.
        s_valid = 1;
        s_data = 8'h5A;
        s_last = 0;
        repeat (5) begin
            @(negedge clk);
            check("post_done", 72'({s_ready, in_ready, msg_len}), 72'({1'b0, 1'b0, 32'd8}));
        end
        @(posedge clk);
        #1;
        s_valid = 0;

        // Reset mid-message, then a one-byte message.
        do_reset();
        mon_en = 1;
        send_byte(8'h21, 0);
        send_byte(8'h22, 0);
        do_reset();
        msg_q.delete();
        msg_q.push_back(8'h11);
        exp_q.push_back({1'b1, 2'd1, 32'h11000000});
        mon_en = 1;
        send_msg();
        wait_done();
        check("restart_msg_len", 72'(msg_len), 72'(1));

        // Randomized messages with random gaps and backpressure.
        for (int r = 0; r < 25; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 14);
            msg_q.delete();
            for (int k = 0; k < n; k++) msg_q.push_back(8'($urandom_range(0, 255)));
            model_expect();
            mon_en = 1;
            gaps_en = 1;
            bf_rand = 1;
            send_msg();
            wait_done();
            bf_rand = 0;
            gaps_en = 0;
            check("rand_msg_len", 72'(msg_len), 72'(n));
        end

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
Name: keccak_byte_packer

Overview:
- Upstream feeder for the keccak hash core.
- Accepts a byte stream (valid/ready, last-flag) and packs it into 32-bit words on the core's input interface: in, in_ready, is_last, byte_num, with buffer_full as backpressure.
- Generates the core's end-of-message framing, including the empty final word when the message length is a multiple of 4.
- Reports message length and completion. One message per reset, matching the core.

Parameters:
LEN_W, 32, width of the accepted-byte counter msg_len (wraps modulo 2^LEN_W).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state.
s_data  input  8  message byte.
s_valid  input  1  s_data valid.
s_last  input  1  qualifies final byte of message (valid only with s_valid).
s_ready  output  1  byte accepted on cycle where s_valid && s_ready.
in  output  32  word to core; first byte of word in [31:24], then [23:16], [15:8], [7:0].
in_ready  output  1  word on `in` valid.
is_last  output  1  word is final word; forced 0 when in_ready=0.
byte_num  output  2  valid bytes in final word (0..3); 0 when is_last=0.
buffer_full  input  1  core cannot accept; word transfers when in_ready && !buffer_full (w_fire).
msg_len  output  LEN_W  count of bytes accepted since reset.
done  output  1  final word (is_last=1) transferred; sticky until reset.

Behaviour:
- Reset values:
  - Outputs: s_ready=0, in=0, in_ready=0, is_last=0, byte_num=0, msg_len=0, done=0.
  - Internal: state=RUN, cnt=0, acc=0.
- Storage:
  - 24-bit accumulator acc with byte counter cnt (0..3).
  - One output word register: word, out_valid, last_r, bn_r. in_ready=out_valid.
- States:
  - RUN: accepting bytes.
  - FLUSH: must emit the empty final word.
  - DONE: idle until reset.
- s_ready = (state==RUN) && (!out_valid || w_fire).
  - Combinational path from buffer_full to s_ready is permitted.
  - s_ready does not depend on s_data or s_last.
- Byte accept in RUN with cnt<3, s_last=0:
  - Byte goes to lane cnt of acc (lane 0 = bits [31:24] of the eventual word).
  - cnt++, msg_len++.
- Byte accept with cnt==3:
  - word={acc,s_data}, out_valid=1 next cycle, last_r=0, cnt=0.
  - If s_last=1: state->FLUSH.
- Byte accept with cnt<3 and s_last=1:
  - word = acc bytes plus s_data in lane cnt, remaining lanes zero.
  - last_r=1, bn_r=cnt+1, cnt=0, state->DONE.
- Latency: the byte completing a word is accepted at edge t; the word is presented from cycle t+1.
- FLUSH:
  - When the output register is free (!out_valid || w_fire), load word=0, last_r=1, bn_r=0, out_valid=1.
  - Then state->DONE.
- w_fire:
  - Clears out_valid unless reloaded the same cycle; a simultaneous reload keeps in_ready=1 with the new word.
  - If the transferred word had last_r=1, done<=1 next cycle.
- Hold rule: while in_ready && buffer_full, in/is_last/byte_num stay stable.
- is_last = out_valid & last_r; byte_num = is_last ? bn_r : 0.
- DONE: s_ready=0; further s_valid ignored. Only reset restarts, since the core also requires reset between messages.
- Reset mid-message: pending word and accumulator are discarded; in_ready=0 the following cycle.
- msg_len wraps modulo 2^LEN_W. No error is flagged.
- Zero-length messages are not supported: framing requires at least one byte carrying s_last.

Test Plan:
- 5 bytes 0x61..0x65 (s_last on 0x65), buffer_full=0 -> required response:
  - Word 0x61626364 with is_last=0.
  - Then 0x65000000 with is_last=1, byte_num=1.
  - done=1, msg_len=5.
- Bytes 0x61..0x64 (s_last on 0x64) -> 0x61626364 is_last=0, then 0x00000000 is_last=1, byte_num=0; msg_len=4.
- Bytes 0xAA,0xBB,0xCC (last) -> single word 0xAABBCC00, is_last=1, byte_num=3, done one cycle after transfer.
- 8-byte stream with buffer_full=1 for 10 cycles while first word is pending -> required response:
  - in held at first word; s_ready=0 throughout.
  - No byte lost; after release, words transfer in order.
- After done, drive s_valid=1 for 5 cycles -> s_ready=0, in_ready=0, msg_len unchanged.
- Assert reset after 2 bytes, then send 1 byte 0x11 (last) -> 0x11000000, is_last=1, byte_num=1, msg_len=1.
